// File: rtl/lc3_arb_pkg.sv
// Shared types and constants for the LC-3 memory-port arbiter.
// The arbiter FSM states and the one-hot to grant-index helper live here.
package lc3_arb_pkg;

   typedef enum logic [1:0] {IDLE, BUSY, GAP} arb_state_t;

   localparam int unsigned ARB_NREQ = 7;
   localparam int unsigned ARB_IDXW = 3;

   // Bit i of the one-hot vector is requester i+1; an all-zero vector maps to 0 (no owner).
   function automatic logic [ARB_IDXW-1:0] onehot_to_idx(input logic [ARB_NREQ-1:0] oh);
      logic [ARB_IDXW-1:0] idx;
      idx = '0;
      for (int i = 0; i < ARB_NREQ; i++) begin
         if (oh[i]) idx = idx | ARB_IDXW'(i + 1);
      end
      return idx;
   endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Request/grant/strobe bundle between the requesters, the memory and the arbiter.
// The master modport is the arbiter side; slave is the requester/memory side.
interface mem_port_arbiter_if
   import lc3_arb_pkg::*;
#(
   parameter int unsigned NREQ = ARB_NREQ,
   parameter int unsigned IDXW = ARB_IDXW
);

   logic [NREQ-1:0] req_read;
   logic [NREQ-1:0] req_write;
   logic            mem_resp;
   logic [NREQ-1:0] sel;
   logic [IDXW-1:0] grant_idx;
   logic            mem_read;
   logic            mem_write;
   logic [NREQ-1:0] resp;
   logic            busy;

   modport master (
      input  req_read, req_write, mem_resp,
      output sel, grant_idx, mem_read, mem_write, resp, busy
   );

   modport slave (
      output req_read, req_write, mem_resp,
      input  sel, grant_idx, mem_read, mem_write, resp, busy
   );

endinterface

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first pending requester after the last winner,
// wrapping from NREQ back to 1.
module rr_pick
   import lc3_arb_pkg::*;
#(
   parameter int unsigned NREQ = ARB_NREQ,
   parameter int unsigned IDXW = ARB_IDXW
) (
   input  logic [NREQ-1:0] pending_i,
   input  logic [IDXW-1:0] last_i,
   output logic [NREQ-1:0] winner_o,
   output logic            valid_o
);

   logic [2*NREQ-1:0] dbl;
   logic [2*NREQ-1:0] dbl_oh;
   logic [NREQ-1:0]   rot;
   logic [NREQ-1:0]   rot_oh;

   // last_i is a 1-based requester number, so shifting by it puts requester last+1 at bit 0.
   always_comb begin
      dbl      = {pending_i, pending_i} >> last_i;
      rot      = dbl[NREQ-1:0];
      rot_oh   = rot & (~rot + NREQ'(1));
      dbl_oh   = {{NREQ{1'b0}}, rot_oh} << last_i;
      winner_o = dbl_oh[NREQ-1:0] | dbl_oh[2*NREQ-1:NREQ];
      valid_o  = |pending_i;
   end

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin owner of the LC-3 shared memory port: grants one requester at a time,
// latches its read/write command, and inserts a dead GAP cycle after every completion.
module mem_port_arbiter
   import lc3_arb_pkg::*;
#(
   parameter int unsigned NREQ = ARB_NREQ,
   parameter int unsigned IDXW = ARB_IDXW
) (
   input logic                clk,
   input logic                rst_n,
   mem_port_arbiter_if.master bus
);

   arb_state_t      state_q, state_d;
   logic [NREQ-1:0] sel_q, sel_d;
   logic [IDXW-1:0] grant_q, grant_d;
   logic [IDXW-1:0] last_q, last_d;
   logic            mem_read_q, mem_read_d;
   logic            mem_write_q, mem_write_d;

   logic [NREQ-1:0] pending;
   logic [NREQ-1:0] winner;
   logic            win_valid;
   logic            win_is_write;

   assign pending = bus.req_read | bus.req_write;
   // A requester asserting both read and write is served as a read.
   assign win_is_write = ~|(winner & bus.req_read);

   rr_pick #(
      .NREQ (NREQ),
      .IDXW (IDXW)
   ) u_rr_pick (
      .pending_i (pending),
      .last_i    (last_q),
      .winner_o  (winner),
      .valid_o   (win_valid)
   );

   always_comb begin
      state_d     = state_q;
      sel_d       = sel_q;
      grant_d     = grant_q;
      last_d      = last_q;
      mem_read_d  = mem_read_q;
      mem_write_d = mem_write_q;

      case (state_q)
         IDLE: begin
            sel_d       = '0;
            grant_d     = '0;
            mem_read_d  = 1'b0;
            mem_write_d = 1'b0;
            if (win_valid) begin
               sel_d       = winner;
               grant_d     = IDXW'(onehot_to_idx(winner));
               last_d      = IDXW'(onehot_to_idx(winner));
               mem_read_d  = ~win_is_write;
               mem_write_d = win_is_write;
               state_d     = BUSY;
            end
         end
         BUSY: begin
            // Requests are ignored here; only the memory completion ends the transaction.
            if (bus.mem_resp) begin
               sel_d       = '0;
               grant_d     = '0;
               mem_read_d  = 1'b0;
               mem_write_d = 1'b0;
               state_d     = GAP;
            end
         end
         GAP: begin
            state_d = IDLE;
         end
         default: begin
            sel_d       = '0;
            grant_d     = '0;
            mem_read_d  = 1'b0;
            mem_write_d = 1'b0;
            state_d     = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         sel_q       <= '0;
         grant_q     <= '0;
         last_q      <= '0;
         mem_read_q  <= 1'b0;
         mem_write_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         sel_q       <= sel_d;
         grant_q     <= grant_d;
         last_q      <= last_d;
         mem_read_q  <= mem_read_d;
         mem_write_q <= mem_write_d;
      end
   end

   assign bus.sel       = sel_q;
   assign bus.grant_idx = grant_q;
   assign bus.mem_read  = mem_read_q;
   assign bus.mem_write = mem_write_q;
   assign bus.busy      = (state_q != IDLE);
   assign bus.resp      = (state_q == BUSY && bus.mem_resp) ? sel_q : '0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: round-robin order, read/write latching,
// spurious completions, back-to-back grants and asynchronous reset.
module tb_mem_port_arbiter;
   import lc3_arb_pkg::*;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   int   ncmp  = 0;
   int   nerr  = 0;

   mem_port_arbiter_if bus ();

   mem_port_arbiter dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      ncmp++;
      assert (obs === exp)
      else begin
         nerr++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic chk_all(input string tag, input logic [6:0] s, input logic [2:0] g,
                          input logic rd, input logic wr, input logic b, input logic [6:0] r);
      #1;
      chk({tag, ".sel"}, 32'(bus.sel), 32'(s));
      chk({tag, ".grant_idx"}, 32'(bus.grant_idx), 32'(g));
      chk({tag, ".mem_read"}, 32'(bus.mem_read), 32'(rd));
      chk({tag, ".mem_write"}, 32'(bus.mem_write), 32'(wr));
      chk({tag, ".busy"}, 32'(bus.busy), 32'(b));
      chk({tag, ".resp"}, 32'(bus.resp), 32'(r));
   endtask

   initial begin
      logic [2:0] rr_exp [5];
      logic [6:0] oh;
      rr_exp = '{3'd1, 3'd2, 3'd5, 3'd1, 3'd2};

      bus.req_read  = '0;
      bus.req_write = '0;
      bus.mem_resp  = 1'b0;
      #3;
      chk_all("reset", 7'd0, 3'd0, 1'b0, 1'b0, 1'b0, 7'd0);
      #10 rst_n = 1'b1;

      // Round robin over requesters 1, 2, 5 starting from last=0.
      bus.req_read = 7'b0010011;
      for (int k = 0; k < 5; k++) begin
         oh = 7'd1 << (rr_exp[k] - 3'd1);
         tick();
         chk_all($sformatf("rr%0d.busy", k), oh, rr_exp[k], 1'b1, 1'b0, 1'b1, 7'd0);
         bus.mem_resp = 1'b1;
         chk_all($sformatf("rr%0d.resp", k), oh, rr_exp[k], 1'b1, 1'b0, 1'b1, oh);
         tick();
         bus.mem_resp = 1'b0;
         chk_all($sformatf("rr%0d.gap", k), 7'd0, 3'd0, 1'b0, 1'b0, 1'b1, 7'd0);
         tick();
         chk_all($sformatf("rr%0d.idle", k), 7'd0, 3'd0, 1'b0, 1'b0, 1'b0, 7'd0);
      end
      bus.req_read = '0;

      // Single read from requester 3, request dropped while BUSY.
      tick();
      bus.req_read = 7'b0000100;
      tick();
      chk_all("rd3.c1", 7'b0000100, 3'd3, 1'b1, 1'b0, 1'b1, 7'd0);
      bus.req_read = '0;
      tick();
      chk_all("rd3.c2", 7'b0000100, 3'd3, 1'b1, 1'b0, 1'b1, 7'd0);
      tick();
      tick();
      bus.mem_resp = 1'b1;
      chk_all("rd3.c4", 7'b0000100, 3'd3, 1'b1, 1'b0, 1'b1, 7'b0000100);
      // mem_resp stays high through GAP and IDLE: both must ignore it.
      tick();
      chk_all("rd3.gap", 7'd0, 3'd0, 1'b0, 1'b0, 1'b1, 7'd0);
      tick();
      chk_all("spur.idle1", 7'd0, 3'd0, 1'b0, 1'b0, 1'b0, 7'd0);
      tick();
      chk_all("spur.idle2", 7'd0, 3'd0, 1'b0, 1'b0, 1'b0, 7'd0);
      bus.mem_resp = 1'b0;

      // One-cycle write pulse from requester 1 is latched until completion.
      bus.req_write = 7'b0000001;
      tick();
      chk_all("wr1.c1", 7'b0000001, 3'd1, 1'b0, 1'b1, 1'b1, 7'd0);
      bus.req_write = '0;
      for (int k = 0; k < 3; k++) begin
         tick();
         chk_all($sformatf("wr1.hold%0d", k), 7'b0000001, 3'd1, 1'b0, 1'b1, 1'b1, 7'd0);
      end
      bus.mem_resp = 1'b1;
      chk_all("wr1.resp", 7'b0000001, 3'd1, 1'b0, 1'b1, 1'b1, 7'b0000001);
      tick();
      bus.mem_resp = 1'b0;
      chk_all("wr1.gap", 7'd0, 3'd0, 1'b0, 1'b0, 1'b1, 7'd0);
      tick();

      // Read and write together from requester 4 resolve to a read.
      bus.req_read  = 7'b0001000;
      bus.req_write = 7'b0001000;
      tick();
      chk_all("rw4", 7'b0001000, 3'd4, 1'b1, 1'b0, 1'b1, 7'd0);
      bus.req_read  = '0;
      bus.req_write = '0;
      bus.mem_resp  = 1'b1;
      tick();
      bus.mem_resp = 1'b0;
      tick();

      // Requester 6 held: back-to-back grants, each with a GAP and 1-cycle resp.
      bus.req_read = 7'b0100000;
      for (int t = 0; t < 3; t++) begin
         tick();
         chk_all($sformatf("b2b%0d.c1", t), 7'b0100000, 3'd6, 1'b1, 1'b0, 1'b1, 7'd0);
         tick();
         chk_all($sformatf("b2b%0d.c2", t), 7'b0100000, 3'd6, 1'b1, 1'b0, 1'b1, 7'd0);
         tick();
         bus.mem_resp = 1'b1;
         chk_all($sformatf("b2b%0d.c3", t), 7'b0100000, 3'd6, 1'b1, 1'b0, 1'b1, 7'b0100000);
         tick();
         bus.mem_resp = 1'b0;
         chk_all($sformatf("b2b%0d.gap", t), 7'd0, 3'd0, 1'b0, 1'b0, 1'b1, 7'd0);
         tick();
         chk_all($sformatf("b2b%0d.idle", t), 7'd0, 3'd0, 1'b0, 1'b0, 1'b0, 7'd0);
      end
      bus.req_read = '0;

      // Reset in the middle of a transaction to requester 2.
      bus.req_read = 7'b0000010;
      tick();
      chk_all("rst.grant", 7'b0000010, 3'd2, 1'b1, 1'b0, 1'b1, 7'd0);
      #2;
      rst_n        = 1'b0;
      bus.mem_resp = 1'b1;
      chk_all("rst.async", 7'd0, 3'd0, 1'b0, 1'b0, 1'b0, 7'd0);
      bus.mem_resp = 1'b0;
      tick();
      chk_all("rst.held", 7'd0, 3'd0, 1'b0, 1'b0, 1'b0, 7'd0);
      rst_n        = 1'b1;
      bus.req_read = 7'b1111111;
      tick();
      chk_all("rst.after", 7'b0000001, 3'd1, 1'b1, 1'b0, 1'b1, 7'd0);
      bus.req_read = '0;
      bus.mem_resp = 1'b1;
      tick();
      bus.mem_resp = 1'b0;
      chk_all("rst.after.gap", 7'd0, 3'd0, 1'b0, 1'b0, 1'b1, 7'd0);
      tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
      $finish;
   end

endmodule
